// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the multi-channel edge event scheduler.
// Holds the edge FSM state encoding and the round-robin winner search.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    ES_S0   = 2'b00,
    ES_EDGE = 2'b11,
    ES_S1   = 2'b01
  } edge_state_t;

  localparam int unsigned MAX_CH = 16;

  // First set bit of pending, scanning ptr, ptr+1, ... modulo n_ch.
  // Returns 0 when nothing is pending; callers qualify with |pending.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] pending,
                                          input int unsigned        ptr,
                                          input int unsigned        n_ch);
    logic        found;
    logic [3:0]  idx;
    int unsigned win;
    found = 1'b0;
    win   = 0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = 4'((ptr + k) % n_ch);
      if ((k < n_ch) && !found && pending[idx]) begin
        found = 1'b1;
        win   = 32'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/edge_pulse_fsm.sv
// Per-channel 3-state Moore rising-edge detector.
// Resets into S1 so a level already high at reset release is not an edge.
module edge_pulse_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);
  import edge_evt_pkg::*;

  edge_state_t state_q;
  edge_state_t state_d;

  always_comb begin
    state_d = ES_S0;
    case (state_q)
      ES_S0:          state_d = in ? ES_EDGE : ES_S0;
      ES_EDGE, ES_S1: state_d = in ? ES_S1   : ES_S0;
      default:        state_d = ES_S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ES_S1;
    end else begin
      state_q <= state_d;
    end
  end

  assign pulse = (state_q == ES_EDGE);

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel rising-edge event scheduler: per-channel edge FSMs, pending
// latches, round-robin arbitration onto one valid/ready port, overrun tracking.
module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_ch,
  output logic [N_CH-1:0]         overrun,
  output logic [CNT_W-1:0]        drop_cnt,
  input  logic                    clr_overrun
);

  localparam int unsigned CH_W = $clog2(N_CH);
  localparam logic [CNT_W+4:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

  logic [N_CH-1:0]   pulse;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [N_CH-1:0]   overrun_q, overrun_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              ev_valid_q, ev_valid_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;

  logic              load;
  logic [CH_W-1:0]   winner;
  logic [N_CH-1:0]   clr_vec;
  logic [N_CH-1:0]   drop_vec;
  logic [MAX_CH-1:0] pend_ext;
  logic [CNT_W+4:0]  drop_sum;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_pulse_fsm u_fsm (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in[g]),
      .pulse (pulse[g])
    );
  end

  always_comb begin
    pend_ext              = '0;
    pend_ext[N_CH-1:0]    = pending_q;
    winner                = CH_W'(rr_pick(pend_ext, 32'(rr_ptr_q), N_CH));
    load                  = (!ev_valid_q || ev_ready) && (|pending_q);

    clr_vec = '0;
    if (load) begin
      clr_vec[winner] = 1'b1;
    end

    // A pulse landing on the cycle its channel is loaded re-arms pending
    // instead of counting as a drop.
    pending_d = (pending_q & ~clr_vec) | pulse;
    drop_vec  = pulse & pending_q & ~clr_vec;

    // Clear first, then fold in this cycle's drops so a new overrun wins.
    overrun_d = (clr_overrun ? '0 : overrun_q) | drop_vec;
    drop_sum  = clr_overrun ? '0 : {5'b0, drop_cnt_q};
    for (int unsigned i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + (CNT_W+5)'(drop_vec[i]);
    end
    drop_cnt_d = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];

    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      ev_valid_d = 1'b1;
      ev_ch_d    = winner;
      rr_ptr_d   = (winner == CH_W'(N_CH - 1)) ? '0 : winner + 1'b1;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overrun_q  <= '0;
      drop_cnt_q <= '0;
      rr_ptr_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Scoreboard bench for edge_event_scheduler: directed stimulus pushes expected
// channels, a negedge monitor pops them on every accepted event.
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] in_a = '0;
  logic       rdy_a = 1'b0, clr_a = 1'b0;
  logic       ev_valid_a;
  logic [1:0] ev_ch_a;
  logic [3:0] overrun_a;
  logic [7:0] drop_a;

  logic [3:0] in_b = '0;
  logic       rdy_b = 1'b0, clr_b = 1'b0;
  logic       ev_valid_b;
  logic [1:0] ev_ch_b;
  logic [3:0] overrun_b;
  logic [1:0] drop_b;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  edge_event_scheduler #(.N_CH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .ev_valid(ev_valid_a), .ev_ready(rdy_a),
    .ev_ch(ev_ch_a), .overrun(overrun_a), .drop_cnt(drop_a), .clr_overrun(clr_a)
  );

  edge_event_scheduler #(.N_CH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .ev_valid(ev_valid_b), .ev_ready(rdy_b),
    .ev_ch(ev_ch_b), .overrun(overrun_b), .drop_cnt(drop_b), .clr_overrun(clr_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid_a && rdy_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch %0d expected no event", ev_ch_a);
      end else begin
        chk("sb_ev_ch", 32'(ev_ch_a), exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with all inputs high: nothing may be reported.
    in_a  = 4'b1111;
    rdy_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rst_no_valid", 32'(ev_valid_a), 0);
    end
    chk("rst_overrun", 32'(overrun_a), 0);
    chk("rst_drop_cnt", 32'(drop_a), 0);
    chk("rst_ev_ch", 32'(ev_ch_a), 0);

    // Single edge latency: edge k sample, valid after edge k+2 for one cycle.
    in_a = 4'b0000;
    tick(2);
    exp_q.push_back(2);
    in_a = 4'b0100;
    tick(1);
    chk("lat_edge_k", 32'(ev_valid_a), 0);
    tick(1);
    chk("lat_edge_k1", 32'(ev_valid_a), 0);
    tick(1);
    chk("lat_edge_k2_valid", 32'(ev_valid_a), 1);
    chk("lat_edge_k2_ch", 32'(ev_ch_a), 2);
    tick(1);
    chk("lat_one_cycle", 32'(ev_valid_a), 0);

    // Reset rr pointer, then all four channels rise together.
    rst_n = 1'b0;
    in_a  = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    in_a = 4'b1111;
    tick(2);
    chk("b2b_pre", 32'(ev_valid_a), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("b2b_valid", 32'(ev_valid_a), 1);
      chk("b2b_ch", 32'(ev_ch_a), i);
    end
    tick(1);
    chk("b2b_done", 32'(ev_valid_a), 0);

    // Stalled consumer: three edges on ch1 -> one out, one pending, one dropped.
    rdy_a = 1'b0;
    in_a  = 4'b0000;
    tick(2);
    for (int p = 0; p < 3; p++) begin
      in_a = 4'b0010;
      tick(1);
      in_a = 4'b0000;
      tick(2);
    end
    chk("stall_valid", 32'(ev_valid_a), 1);
    chk("stall_ch", 32'(ev_ch_a), 1);
    chk("ovr_flag", 32'(overrun_a), 32'h2);
    chk("ovr_drop_cnt", 32'(drop_a), 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("clr_overrun", 32'(overrun_a), 0);
    chk("clr_drop_cnt", 32'(drop_a), 0);
    chk("clr_hold_ch", 32'(ev_ch_a), 1);
    exp_q.push_back(1);
    exp_q.push_back(1);
    rdy_a = 1'b1;
    tick(3);
    chk("drain_done", 32'(ev_valid_a), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    // Mid-operation asynchronous reset discards presented and pending events.
    rdy_a = 1'b0;
    in_a  = 4'b1000;
    tick(3);
    chk("mid_valid", 32'(ev_valid_a), 1);
    chk("mid_ch", 32'(ev_ch_a), 3);
    in_a = 4'b1001;
    tick(2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(ev_valid_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_a = 1'b1;
    tick(5);
    chk("post_rst_idle", 32'(ev_valid_a), 0);

    // Narrow counter: single-channel drops saturate at 3.
    for (int n = 1; n <= 7; n++) begin
      in_b = 4'b0001;
      tick(1);
      in_b = 4'b0000;
      tick(2);
      chk("sat_drop", 32'(drop_b), (n <= 2) ? 0 : ((n - 2 > 3) ? 3 : n - 2));
    end
    chk("sat_overrun", 32'(overrun_b), 32'h1);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("sat_clr", 32'(drop_b), 0);

    // Multiple channels dropping in one cycle add together, saturating.
    in_b = 4'b1111;
    tick(1);
    in_b = 4'b0000;
    tick(2);
    chk("multi1_drop", 32'(drop_b), 1);
    chk("multi1_ovr", 32'(overrun_b), 32'h1);
    in_b = 4'b1111;
    tick(1);
    in_b = 4'b0000;
    tick(2);
    chk("multi2_drop", 32'(drop_b), 3);
    chk("multi2_ovr", 32'(overrun_b), 32'hF);

    // Clear coinciding with a new drop: the drop survives, others clear.
    in_b = 4'b0001;
    tick(1);
    in_b  = 4'b0000;
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("clrwin_drop", 32'(drop_b), 1);
    chk("clrwin_ovr", 32'(overrun_b), 32'h1);
    tick(1);
    chk("clrwin_hold", 32'(drop_b), 1);

    chk("sb_final_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
